// File: rtl/auc_wnaf_encoder.sv
// Width-4 NAF recoder: builds digits LSB-first into a buffer, then streams them
// MSB-first as {sign, one-hot magnitude} over a valid/ready handshake.
module auc_wnaf_encoder #(
    parameter int KWID   = 256,
    parameter int WINDOW = 4,
    parameter int CWID   = 9,
    localparam int MWID  = 2 ** (WINDOW - 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            aenc_start,
    input  logic [KWID-1:0] aenc_scalar,
    output logic            aenc_busy,
    output logic            aenc_vld,
    input  logic            aenc_ordy,
    output logic [MWID-1:0] aenc_naf_vlue,
    output logic            aenc_sign,
    output logic            aenc_last
);

    typedef enum logic [1:0] {S_IDLE, S_RECODE, S_EMIT} state_t;

    state_t            state_q;
    logic [KWID:0]     kr_q, kr_d, dext, diff;
    logic [CWID-1:0]   len_q, idx_q, rd_a;
    logic [WINDOW-1:0] r;
    logic [WINDOW-3:0] m;
    logic [MWID:0]     dig, rd_d;
    logic              buf_we;

    // Each entry holds {sign, one-hot magnitude}; zero digit is all-zero.
    logic [MWID:0] buf_mem [KWID+1];

    always_comb begin
        r    = kr_q[WINDOW-1:0];
        // Negative residues mirror the magnitude index: 9->7, 11->5, 13->3, 15->1.
        m    = r[WINDOW-2:1] ^ {(WINDOW-2){r[WINDOW-1]}};
        dig  = r[0] ? {r[WINDOW-1], {1'b1, {(MWID-1){1'b0}}} >> m} : '0;
        dext = r[0] ? {{(KWID+1-WINDOW){r[WINDOW-1]}}, r} : '0;
        diff = kr_q - dext;
        kr_d = diff >> 1;
        buf_we = (state_q == S_RECODE) && ((kr_q != '0) || (len_q == '0));
        rd_a = aenc_vld ? idx_q - 1'b1 : len_q - 1'b1;
        rd_d = buf_mem[rd_a];
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[len_q] <= dig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            kr_q          <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            aenc_busy     <= 1'b0;
            aenc_vld      <= 1'b0;
            aenc_naf_vlue <= '0;
            aenc_sign     <= 1'b0;
            aenc_last     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (aenc_start) begin
                        kr_q      <= {1'b0, aenc_scalar};
                        len_q     <= '0;
                        aenc_busy <= 1'b1;
                        state_q   <= S_RECODE;
                    end
                end
                S_RECODE: begin
                    if (kr_q == '0) begin
                        if (len_q == '0) len_q <= CWID'(1);
                        state_q <= S_EMIT;
                    end else begin
                        kr_q  <= kr_d;
                        len_q <= len_q + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (!aenc_vld) begin
                        aenc_vld      <= 1'b1;
                        idx_q         <= rd_a;
                        {aenc_sign, aenc_naf_vlue} <= rd_d;
                        aenc_last     <= (rd_a == '0);
                    end else if (aenc_ordy) begin
                        if (idx_q == '0) begin
                            aenc_vld      <= 1'b0;
                            aenc_busy     <= 1'b0;
                            aenc_naf_vlue <= '0;
                            aenc_sign     <= 1'b0;
                            aenc_last     <= 1'b0;
                            state_q       <= S_IDLE;
                        end else begin
                            idx_q         <= rd_a;
                            {aenc_sign, aenc_naf_vlue} <= rd_d;
                            aenc_last     <= (rd_a == '0);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
